// File: rtl/simd_host_pkg.sv
// Shared types and constants for the PS-side BRAM loader.
package simd_host_pkg;

  // Host command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    LOAD_INS = 2'd2,
    READ_R   = 2'd3
  } host_op_e;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    EMIT    = 3'd5,
    DONE    = 3'd6
  } loader_state_e;

  // Cycles from driving bram_r_r_addr until bram_r_r_data is valid.
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/ps_bram_loader_if.sv
// PS-facing command and word-stream bundle of the BRAM loader.
interface ps_bram_loader_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INS_ADDR_WIDTH = 11
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [INS_ADDR_WIDTH-1:0] cmd_base;
  logic [INS_ADDR_WIDTH:0]   cmd_len;

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_WIDTH-1:0]     s_data;

  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_WIDTH-1:0]     m_data;
  logic                      m_last;

  // Processing-system side.
  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    input  cmd_ready,
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready
  );

  // Loader side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    output cmd_ready,
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready
  );

endinterface

// File: rtl/ps_row_packer.sv
// Row register with a lane counter: packs words into a row on load,
// and unpacks a captured row back into words on readback.
module ps_row_packer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CntW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       word_in,
  input  logic                   load,
  input  logic [LANES*WIDTH-1:0] row_in,
  input  logic                   pop,
  output logic [LANES*WIDTH-1:0] row,
  output logic [CntW-1:0]        cnt,
  output logic [WIDTH-1:0]       word_out
);

  logic [LANES-1:0][WIDTH-1:0] row_q;
  logic [CntW-1:0]             cnt_q;

  // Row storage: full-row capture on load, single lane write on push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
    end else if (load) begin
      row_q <= row_in;
    end else if (push) begin
      row_q[cnt_q] <= word_in;
    end
  end

  // Lane counter: selects the lane written by push or presented for pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear || load) begin
      cnt_q <= '0;
    end else if (push || pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign row      = row_q;
  assign cnt      = cnt_q;
  assign word_out = row_q[cnt_q];

endmodule

// File: rtl/ps_bram_loader.sv
// Host bridge to the datapath PS ports: packs the inbound word stream into
// A/B/INS BRAM rows, and serialises R BRAM rows onto the outbound stream.
// The datapath is held in stall for the whole of each command.
module ps_bram_loader
  import simd_host_pkg::*;
#(
  parameter int unsigned PE_COUNT       = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BRAM_DEPTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(BRAM_DEPTH),
  parameter int unsigned INS_ADDR_WIDTH = 11,
  parameter int unsigned INS_WIDTH      = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  ps_bram_loader_if.slave                ps,
  output logic                           stall,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_a_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_a_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_wr_data,
  output logic                           bram_b_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_b_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_wr_data,
  output logic                           bram_ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0]      bram_ins_wr_addr,
  output logic [INS_WIDTH-1:0]           bram_ins_wr_data,
  output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data
);

  localparam int unsigned CntW  = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int unsigned WaitW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned LenW  = INS_ADDR_WIDTH + 1;

  loader_state_e             state_q, state_d;
  host_op_e                  op_q, op_d;
  logic [INS_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LenW-1:0]           len_q, len_d;
  logic [LenW-1:0]           row_q, row_d;
  logic [WaitW-1:0]          wait_q, wait_d;
  logic                      armed_q;

  logic                           cmd_ready;
  logic                           accept;
  logic [INS_ADDR_WIDTH-1:0]      row_addr;
  logic                           row_last;
  logic                           lane_last;
  logic                           word_last;
  logic                           wait_last;

  logic                           pk_clear;
  logic                           pk_push;
  logic                           pk_load;
  logic                           pk_pop;
  logic [PE_COUNT*DATA_WIDTH-1:0] pk_row;
  logic [CntW-1:0]                pk_cnt;
  logic [DATA_WIDTH-1:0]          pk_word;

  // armed_q keeps cmd_ready low until the first clock after reset release.
  assign cmd_ready = armed_q && (state_q == IDLE);
  assign accept    = ps.cmd_valid && cmd_ready;

  // Row address wraps modulo the port width; A/B take the low bits of it.
  assign row_addr  = base_q + row_q[INS_ADDR_WIDTH-1:0];
  assign row_last  = (row_q == len_q - 1'b1);
  assign lane_last = (pk_cnt == CntW'(PE_COUNT - 1));
  assign word_last = (op_q == LOAD_INS) ? (pk_cnt == CntW'(1)) : lane_last;
  assign wait_last = (wait_q == WaitW'(RD_LATENCY - 1));

  assign pk_clear = (state_q == IDLE) || (state_q == WRITE);
  assign pk_push  = (state_q == COLLECT) && ps.s_valid;
  assign pk_load  = (state_q == RD_WAIT) && wait_last;
  assign pk_pop   = (state_q == EMIT) && ps.m_ready;

  ps_row_packer #(
    .LANES(PE_COUNT),
    .WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (pk_clear),
    .push    (pk_push),
    .word_in (ps.s_data),
    .load    (pk_load),
    .row_in  (bram_r_r_data),
    .pop     (pk_pop),
    .row     (pk_row),
    .cnt     (pk_cnt),
    .word_out(pk_word)
  );

  // Next-state and command-context logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    len_d   = len_q;
    row_d   = row_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = host_op_e'(ps.cmd_op);
          base_d = ps.cmd_base;
          len_d  = ps.cmd_len;
          row_d  = '0;
          if (ps.cmd_len == '0) begin
            state_d = DONE;
          end else if (ps.cmd_op == READ_R) begin
            state_d = RD_ADDR;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (ps.s_valid && word_last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        row_d   = row_q + 1'b1;
        state_d = row_last ? DONE : COLLECT;
      end
      RD_ADDR: begin
        wait_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_last) begin
          state_d = EMIT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EMIT: begin
        if (ps.m_ready && lane_last) begin
          if (row_last) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and command-context registers; reset discards any partial command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= LOAD_A;
      base_q  <= '0;
      len_q   <= '0;
      row_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      len_q   <= len_d;
      row_q   <= row_d;
      wait_q  <= wait_d;
    end
  end

  // Becomes set on the first clock after reset release and stays set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // BRAM write strobes: a single write to the BRAM selected by the op.
  always_comb begin
    bram_a_wr_en     = 1'b0;
    bram_a_wr_addr   = '0;
    bram_a_wr_data   = '0;
    bram_b_wr_en     = 1'b0;
    bram_b_wr_addr   = '0;
    bram_b_wr_data   = '0;
    bram_ins_wr_en   = 1'b0;
    bram_ins_wr_addr = '0;
    bram_ins_wr_data = '0;
    if (state_q == WRITE) begin
      unique case (op_q)
        LOAD_A: begin
          bram_a_wr_en   = 1'b1;
          bram_a_wr_addr = row_addr[ADDR_WIDTH-1:0];
          bram_a_wr_data = pk_row;
        end
        LOAD_B: begin
          bram_b_wr_en   = 1'b1;
          bram_b_wr_addr = row_addr[ADDR_WIDTH-1:0];
          bram_b_wr_data = pk_row;
        end
        LOAD_INS: begin
          bram_ins_wr_en   = 1'b1;
          bram_ins_wr_addr = row_addr;
          // First word lands in the low half, second in the high half.
          bram_ins_wr_data = pk_row[INS_WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Read address is held through the wait so the BRAM sees a stable address.
  assign bram_r_r_addr = ((state_q == RD_ADDR) || (state_q == RD_WAIT)) ? row_addr : '0;

  assign ps.cmd_ready = cmd_ready;
  assign ps.s_ready   = (state_q == COLLECT);
  assign ps.m_valid   = (state_q == EMIT);
  assign ps.m_data    = (state_q == EMIT) ? pk_word : '0;
  assign ps.m_last    = (state_q == EMIT) && lane_last && row_last;

  assign stall = (state_q != IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_ps_bram_loader.sv
// Randomised self-checking bench for ps_bram_loader against a row/word model.
module tb_ps_bram_loader;

  localparam int unsigned PE  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned IAW = 11;

  typedef struct {
    int           sel;
    int           addr;
    logic [127:0] data;
    int           cyc;
  } wr_t;

  logic clk;
  logic rstn;

  logic               stall, busy, done;
  logic               a_en, b_en, ins_en;
  logic [AW-1:0]      a_addr, b_addr;
  logic [PE*DW-1:0]   a_data, b_data;
  logic [IAW-1:0]     ins_addr, r_addr;
  logic [63:0]        ins_data;
  logic [PE*DW-1:0]   r_rdata;
  logic [PE*DW-1:0]   r_s1;

  logic [127:0] r_mem [0:2047];
  logic [31:0]  stim_words [$];
  wr_t          wr_log [$];

  int cyc        = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int stall_cnt  = 0;
  int n_checks   = 0;
  int n_pass     = 0;

  ps_bram_loader_if #(.DATA_WIDTH(DW), .INS_ADDR_WIDTH(IAW)) ps_if ();

  ps_bram_loader dut (
    .clk             (clk),
    .rstn            (rstn),
    .ps              (ps_if),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .bram_a_wr_en    (a_en),
    .bram_a_wr_addr  (a_addr),
    .bram_a_wr_data  (a_data),
    .bram_b_wr_en    (b_en),
    .bram_b_wr_addr  (b_addr),
    .bram_b_wr_data  (b_data),
    .bram_ins_wr_en  (ins_en),
    .bram_ins_wr_addr(ins_addr),
    .bram_ins_wr_data(ins_data),
    .bram_r_r_addr   (r_addr),
    .bram_r_r_data   (r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage read BRAM for R.
  always @(posedge clk) begin
    r_s1    <= r_mem[r_addr];
    r_rdata <= r_s1;
  end

  // Write, done and stall monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_en)   wr_log.push_back('{0, int'(a_addr), a_data, cyc});
    if (b_en)   wr_log.push_back('{1, int'(b_addr), b_data, cyc});
    if (ins_en) wr_log.push_back('{2, int'(ins_addr), 128'(ins_data), cyc});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (stall) stall_cnt = stall_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Issues a command; returns at mid-cycle of the first cycle after accept.
  task automatic send_cmd(input int op, input int base, input int len, output int acc);
    int g = 0;
    ps_if.cmd_valid = 1'b1;
    ps_if.cmd_op    = 2'(op);
    ps_if.cmd_base  = IAW'(base);
    ps_if.cmd_len   = (IAW + 1)'(len);
    while (!ps_if.cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!ps_if.cmd_ready) check("cmd_accept", 128'(ps_if.cmd_ready), 128'(1));
    acc = cyc;
    @(negedge clk);
    ps_if.cmd_valid = 1'b0;
    check("cmd_ready_busy", 128'(ps_if.cmd_ready), 128'(0));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!done) check({tag, "_done_seen"}, 128'(done), 128'(1));
    repeat (2) @(negedge clk);
  endtask

  // Load command: feeds stim_words, then checks every write against the model.
  task automatic run_load(input int op, input int base, input int len, input bit gaps);
    int wpr   = (op == 2) ? 2 : PE;
    int n     = len * wpr;
    int idx   = 0;
    int g     = 0;
    int acc;
    int d0    = done_cnt;
    wr_log.delete();
    send_cmd(op, base, len, acc);
    while (idx < n && g < 2000) begin
      ps_if.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ps_if.s_data  = stim_words[idx];
      if (ps_if.s_valid && ps_if.s_ready) idx++;
      @(negedge clk);
      g++;
    end
    ps_if.s_valid = 1'b0;
    wait_done("ld");
    check("ld_words", 128'(idx), 128'(n));
    check("ld_wr_count", 128'(wr_log.size()), 128'(len));
    for (int r = 0; r < len; r++) begin
      int           wa;
      logic [127:0] wd;
      if (op == 2) begin
        wa = (base + r) % 2048;
        wd = {64'd0, stim_words[2*r+1], stim_words[2*r]};
      end else begin
        wa = (base + r) % 1024;
        wd = {stim_words[4*r+3], stim_words[4*r+2], stim_words[4*r+1], stim_words[4*r]};
      end
      if (r < wr_log.size()) begin
        check("wr_sel", 128'(wr_log[r].sel), 128'(op));
        check("wr_addr", 128'(wr_log[r].addr), 128'(wa));
        check("wr_data", wr_log[r].data, wd);
        if (!gaps) check("wr_time", 128'(wr_log[r].cyc - acc), 128'((r + 1) * (wpr + 1)));
      end
    end
    check("ld_done_cnt", 128'(done_cnt - d0), 128'(1));
    if (wr_log.size() > 0)
      check("ld_done_time", 128'(done_cyc), 128'(wr_log[wr_log.size()-1].cyc + 1));
  endtask

  // Readback: collects the outbound stream and compares word by word.
  task automatic run_read(input int base, input int len, input bit rnd);
    logic [31:0] exp_d [$];
    bit          exp_l [$];
    int          n     = len * PE;
    int          got   = 0;
    int          g     = 0;
    int          acc;
    int          last_cyc = 0;
    int          d0    = done_cnt;
    bit          seen  = 1'b0;
    bit          held  = 1'b0;
    logic [32:0] hv    = '0;
    wr_log.delete();
    for (int r = 0; r < len; r++) begin
      logic [127:0] row = r_mem[(base + r) % 2048];
      for (int k = 0; k < PE; k++) begin
        exp_d.push_back(row[k*32 +: 32]);
        exp_l.push_back((k == PE - 1) && (r == len - 1));
      end
    end
    send_cmd(3, base, len, acc);
    while (got < n && g < 2000) begin
      ps_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ps_if.m_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("rd_first_latency", 128'(cyc - acc), 128'(4));
        end
        if (held) check("rd_hold", 128'({ps_if.m_last, ps_if.m_data}), 128'(hv));
        if (ps_if.m_ready) begin
          check("rd_data", 128'(ps_if.m_data), 128'(exp_d[got]));
          check("rd_last", 128'(ps_if.m_last), 128'(exp_l[got]));
          got++;
          held     = 1'b0;
          last_cyc = cyc;
        end else begin
          held = 1'b1;
          hv   = {ps_if.m_last, ps_if.m_data};
        end
      end
      @(negedge clk);
      g++;
    end
    ps_if.m_ready = 1'b0;
    check("rd_words", 128'(got), 128'(n));
    wait_done("rd");
    if (!rnd) check("rd_total_time", 128'(last_cyc - acc), 128'(len * (PE + 3)));
    check("rd_done_cnt", 128'(done_cnt - d0), 128'(1));
    check("rd_done_time", 128'(done_cyc), 128'(last_cyc + 1));
    check("rd_no_writes", 128'(wr_log.size()), 128'(0));
  endtask

  task automatic rand_words(input int n);
    stim_words.delete();
    for (int i = 0; i < n; i++) stim_words.push_back($urandom);
  endtask

  initial begin
    int acc;
    int d0;
    int s0;
    logic [1023:0] outs;

    rstn            = 1'b0;
    ps_if.cmd_valid = 1'b0;
    ps_if.cmd_op    = '0;
    ps_if.cmd_base  = '0;
    ps_if.cmd_len   = '0;
    ps_if.s_valid   = 1'b0;
    ps_if.s_data    = '0;
    ps_if.m_ready   = 1'b0;
    for (int i = 0; i < 2048; i++) r_mem[i] = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    outs = 1024'({ps_if.cmd_ready, ps_if.s_ready, ps_if.m_valid, ps_if.m_last, ps_if.m_data,
                  stall, busy, done, a_en, a_addr, a_data, b_en, b_addr, b_data,
                  ins_en, ins_addr, ins_data, r_addr});
    check("rst_outputs_zero", 128'(|outs), 128'(0));
    check("rst_cmd_ready", 128'(ps_if.cmd_ready), 128'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 128'(ps_if.cmd_ready), 128'(1));

    // LOAD_A, base 0, two rows of 1..8.
    stim_words.delete();
    for (int i = 1; i <= 8; i++) stim_words.push_back(32'(i));
    run_load(0, 0, 2, 1'b0);

    // LOAD_INS, single instruction.
    stim_words.delete();
    stim_words.push_back(32'hDEADBEEF);
    stim_words.push_back(32'h12345678);
    run_load(2, 5, 1, 1'b0);

    // READ_R with backpressure.
    r_mem[3] = {32'd40, 32'd30, 32'd20, 32'd10};
    r_mem[4] = {32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    run_read(3, 2, 1'b1);
    run_read(3, 2, 1'b0);

    // LOAD_B wrapping past the top of the BRAM.
    rand_words(8);
    run_load(1, 1023, 2, 1'b1);

    // Zero-length command.
    d0 = done_cnt;
    s0 = stall_cnt;
    wr_log.delete();
    send_cmd(1, 9, 0, acc);
    wait_done("len0");
    check("len0_done_cnt", 128'(done_cnt - d0), 128'(1));
    check("len0_done_time", 128'(done_cyc - acc), 128'(1));
    check("len0_stall_cycles", 128'(stall_cnt - s0), 128'(1));
    check("len0_no_writes", 128'(wr_log.size()), 128'(0));

    // Reset in the middle of a LOAD_A row.
    rand_words(4);
    wr_log.delete();
    d0 = done_cnt;
    send_cmd(0, 7, 1, acc);
    for (int i = 0; i < 2; i++) begin
      ps_if.s_valid = 1'b1;
      ps_if.s_data  = stim_words[i];
      @(negedge clk);
    end
    ps_if.s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    outs = 1024'({ps_if.cmd_ready, ps_if.s_ready, ps_if.m_valid, ps_if.m_last, ps_if.m_data,
                  stall, busy, done, a_en, a_addr, a_data, b_en, b_addr, b_data,
                  ins_en, ins_addr, ins_data, r_addr});
    check("midrst_outputs_zero", 128'(|outs), 128'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_no_write", 128'(wr_log.size()), 128'(0));
    check("midrst_no_done", 128'(done_cnt - d0), 128'(0));
    check("midrst_cmd_ready", 128'(ps_if.cmd_ready), 128'(1));
    rand_words(4);
    run_load(0, 7, 1, 1'b0);

    // Random command mix.
    for (int t = 0; t < 8; t++) begin
      int op   = $urandom_range(0, 3);
      int base = $urandom_range(0, 2047);
      int len  = $urandom_range(1, 3);
      bit gaps = 1'($urandom_range(0, 1));
      if (op == 3) begin
        for (int r = 0; r < len; r++)
          r_mem[(base + r) % 2048] = {$urandom, $urandom, $urandom, $urandom};
        run_read(base, len, gaps);
      end else begin
        rand_words(len * ((op == 2) ? 2 : PE));
        run_load(op, base, len, gaps);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
